// File: rtl/ir_pkg.sv
// ir_pkg
// Shared types and constants for the IR line-sensor error calculator:
// sweep state encoding, sensor channel map, datapath widths and the
// position-weight helpers.

package ir_pkg;

   localparam int ERR_W = 16;
   localparam int A2D_W = 12;
   localparam int CH_W  = 3;

   // Even channels sit left of centre, odd channels right of centre;
   // the pair index (idx>>1) moves outward from the middle.
   localparam logic [CH_W-1:0] CH_L_INNER = 3'd0;
   localparam logic [CH_W-1:0] CH_R_INNER = 3'd1;
   localparam logic [CH_W-1:0] CH_L_MID   = 3'd2;
   localparam logic [CH_W-1:0] CH_R_MID   = 3'd3;
   localparam logic [CH_W-1:0] CH_L_OUTER = 3'd4;
   localparam logic [CH_W-1:0] CH_R_OUTER = 3'd5;
   localparam logic [CH_W-1:0] CH_LAST    = CH_R_OUTER;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CONV,
      S_WAIT,
      S_DONE
   } ir_state_e;

   // Weight exponent: inner pair x1, mid pair x2, outer pair x4.
   function automatic logic [1:0] wt_exp(input logic [CH_W-1:0] idx);
      return 2'(idx >> 1);
   endfunction

   // Right-hand sensors pull the error positive, left-hand ones negative.
   function automatic logic is_right(input logic [CH_W-1:0] idx);
      return (idx & 3'd1) != 3'd0;
   endfunction

endpackage

// File: rtl/ir_err_calc_if.sv
// ir_err_calc_if
// Start/complete handshake between the error calculator (master) and the
// A2D converter (slave).

interface ir_err_calc_if;
   import ir_pkg::*;

   logic             strt_cnv;
   logic [CH_W-1:0]  chnnl;
   logic             cnv_cmplt;
   logic [A2D_W-1:0] res;

   modport master (
      output strt_cnv,
      output chnnl,
      input  cnv_cmplt,
      input  res
   );

   modport slave (
      input  strt_cnv,
      input  chnnl,
      output cnv_cmplt,
      output res
   );

endinterface

// File: rtl/ir_period_tmr.sv
// ir_period_tmr
// Free-running sweep period counter. Counts 0..PERIOD-1 while enabled and
// is held at zero while disabled, so a fresh enable always waits a full
// period before the first tick.

module ir_period_tmr #(
   parameter int PERIOD = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Period count: cleared on reset or disable, wraps at the tick.
   always_ff @(posedge clk) begin
      if (rst || !en)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/ir_err_calc.sv
// ir_err_calc
// Sensing front end for the line follower's PID loop. Each period it turns
// the IR emitters on, waits for them to settle, converts the six sensors in
// turn and folds the readings into a signed position-weighted error.
// Optional feature macro: IR_ERR_FILTER_EN averages each new error with the
// previous one (the first sweep after reset or enable loads unfiltered).

module ir_err_calc
   import ir_pkg::*;
#(
   parameter int PERIOD = 4096,
   parameter int SETTLE = 256,
   parameter logic [A2D_W-1:0] LINE_THRES = 12'h200
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   ir_err_calc_if.master           a2d,
   output logic                    IR_en,
   output logic signed [ERR_W-1:0] error,
   output logic                    err_vld,
   output logic                    line_present
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   ir_state_e        state, nxt_state;
   logic             tick;
   logic             strt_cnv;
   logic [CH_W-1:0]  idx;
   logic [SW-1:0]    settle_cnt;
   logic [ERR_W-1:0] acc, acc_nxt, term, err_load;
   logic             line_flag, flag_nxt;

   ir_period_tmr #(.PERIOD(PERIOD)) u_tmr (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   assign a2d.strt_cnv = strt_cnv;
   assign a2d.chnnl    = idx;

   // Weighted term for the reading arriving now, and the running sums it produces.
   always_comb begin
      term     = ERR_W'(a2d.res) << wt_exp(idx);
      acc_nxt  = is_right(idx) ? (acc + term) : (acc - term);
      flag_nxt = line_flag | (a2d.res > LINE_THRES);
   end

`ifdef IR_ERR_FILTER_EN
   logic signed [ERR_W:0] filt_sum;
   logic                  first_sweep;

   assign filt_sum = $signed({acc_nxt[ERR_W-1], acc_nxt}) + $signed({error[ERR_W-1], error});
   assign err_load = first_sweep ? acc_nxt : ERR_W'(filt_sum >>> 1);

   // Remember whether the filter has a valid history since reset or enable.
   always_ff @(posedge clk) begin
      if (rst || !en)
         first_sweep <= 1'b1;
      else if (state == S_WAIT && a2d.cnv_cmplt && idx == CH_LAST)
         first_sweep <= 1'b0;
   end
`else
   assign err_load = acc_nxt;
`endif

   // Sweep state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= nxt_state;
   end

   // Sweep sequencing and the per-state outputs; dropping en aborts any sweep.
   always_comb begin
      nxt_state = state;
      IR_en     = 1'b0;
      err_vld   = 1'b0;
      strt_cnv  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (en && tick)
               nxt_state = S_SETTLE;
         end
         S_SETTLE: begin
            IR_en = 1'b1;
            if (!en)
               nxt_state = S_IDLE;
            else if (settle_cnt == SETTLE_LAST)
               nxt_state = S_CONV;
         end
         S_CONV: begin
            IR_en    = 1'b1;
            strt_cnv = 1'b1;
            nxt_state = en ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            IR_en = 1'b1;
            if (!en)
               nxt_state = S_IDLE;
            else if (a2d.cnv_cmplt)
               nxt_state = (idx == CH_LAST) ? S_DONE : S_CONV;
         end
         S_DONE: begin
            err_vld   = 1'b1;
            nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   // Sweep datapath: settle timer, channel index, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx          <= '0;
         settle_cnt   <= '0;
         acc          <= '0;
         line_flag    <= 1'b0;
         error        <= '0;
         line_present <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (en && tick) begin
                  idx        <= '0;
                  settle_cnt <= '0;
                  acc        <= '0;
                  line_flag  <= 1'b0;
               end
            end
            S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
            S_WAIT: begin
               if (en && a2d.cnv_cmplt) begin
                  acc       <= acc_nxt;
                  line_flag <= flag_nxt;
                  if (idx == CH_LAST) begin
                     error        <= err_load;
                     line_present <= flag_nxt;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
